result_uart_tx: RTL
===================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving the clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 The block SHALL have parameter MAX_CLASS, default 9, giving the largest valid class index.
REQ-003 Port clk: input, 1 bit; the single clock, and all state SHALL update on its rising edge.
REQ-004 Port rst: input, 1 bit; the reset SHALL be synchronous and active-high.
REQ-005 Port rd: input, 1 bit; classification result ready, a level that stays high until the producer sees tx_done.
REQ-006 Port din: input, 8 bits; classification byte, with the class index in din[3:0] and din[7:4] ignored.
REQ-007 Port tx_done: output, 1 bit; single-cycle pulse when the whole message has been sent.
REQ-008 Port TX: output, 1 bit; UART serial line, 8N1, LSB first, idle high.
REQ-009 Port busy: output, 1 bit; high while a message is in progress.

Function
REQ-010 Trigger SHALL be the rising edge of rd: rd=1 in the current cycle and rd=0 in the previous cycle (registered copy rd_q).
REQ-011 On a trigger in IDLE, the block SHALL latch din[3:0] in that same cycle, set the byte index to 0, and enter START on the next edge.
REQ-012 Triggers while busy=1 SHALL be ignored; rd_q SHALL still track rd.
REQ-013 The message SHALL be 3 bytes in order:
- byte 0: ASCII digit (0x30 + index) when index <= MAX_CLASS, otherwise 0x3F ('?');
- byte 1: 0x0D;
- byte 2: 0x0A.
REQ-014 The FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on trigger.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bits of CLKS_PER_BIT cycles each.
- STOP -> START after CLKS_PER_BIT cycles if byte index < 2 (index increments).
- STOP -> IDLE after CLKS_PER_BIT cycles if byte index == 2.
REQ-015 TX SHALL be 0 in START, shift-register bit 0 in DATA, and 1 in STOP and IDLE; TX SHALL be driven from a register (glitch-free).
REQ-016 The baud counter SHALL count 0..CLKS_PER_BIT-1, SHALL wrap to 0 on each bit boundary, and SHALL be held at 0 in IDLE.
- Its width SHALL be $clog2(CLKS_PER_BIT).
REQ-017 The bit counter SHALL count 0..7 in DATA; the shift register SHALL shift right once per bit boundary.
REQ-018 Each byte SHALL be loaded into the shift register on entry to START.
REQ-019 There SHALL be no idle gap between bytes: the STOP bit of byte n SHALL be followed immediately by the START bit of byte n+1.
REQ-020 TX SHALL fall exactly 1 cycle after the trigger cycle, and the total message SHALL last exactly 30*CLKS_PER_BIT cycles.
REQ-021 tx_done SHALL be high for exactly 1 cycle: the cycle in which the state first reads IDLE after the final STOP bit.
REQ-022 busy SHALL equal (state != IDLE), so busy=0 during the tx_done cycle.
REQ-023 A trigger coincident with the tx_done cycle SHALL be accepted (back-to-back messages).
REQ-024 If rd falls mid-message, the message SHALL complete unaffected.

Reset
REQ-025 While rst=1, the block SHALL apply: state=IDLE, TX=1, tx_done=0, busy=0, rd_q=0, and all counters, the byte index and the shift register = 0.
REQ-026 Reset asserted mid-message SHALL abort the message on the next edge, with TX=1 and no tx_done pulse.
REQ-027 rst SHALL take priority over every other input.
REQ-028 If rd is already high when rst releases, that SHALL count as a rising edge, because rd_q resets to 0.

Verification (CLKS_PER_BIT=4)
REQ-029 Scenario, single message: rd 0->1 with din=0x07 -> TX carries 0x37, 0x0D, 0x0A with 4 cycles per bit; tx_done pulses once at trigger+121 cycles; busy is high for cycles 1..120.
REQ-030 Scenario, out-of-range index: din=0x0C -> byte 0 is 0x3F; din=0xF5 -> byte 0 is 0x35 (upper nibble ignored).
REQ-031 Scenario, held and re-pulsed rd: rd held high through the whole message, and a second 0->1 pulse at cycle 40 -> exactly 1 message is sent and 1 tx_done pulse occurs.
REQ-032 Scenario, back-to-back: rd dropped, then re-raised so the rising edge lands on the tx_done cycle -> the second START bit begins the next cycle, with no extra idle bit.
REQ-033 Scenario, reset mid-message: rst=1 at cycle 50 for 1 cycle -> TX=1 and busy=0 on the next edge; no tx_done; a new trigger afterwards sends a clean full message.
REQ-034 Scenario, bit timing: on every bit, TX holds stable for exactly CLKS_PER_BIT cycles; the checker samples each bit at its midpoint and compares against the expected 3-byte sequence.

Source files
------------

// File: rtl/result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : result_uart_tx
//  Purpose  : Sends a classification result as a 3-byte ASCII message
//             (digit or '?', CR, LF) over an 8N1 UART line, LSB first.
//  Revision : 1.0 - initial release
// ============================================================================
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_CLASS    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd,
  input  logic [7:0] din,
  output logic       tx_done,
  output logic       TX,
  output logic       busy
);

  // A 1-cycle bit period would give a zero-width counter; keep at least one bit.
  localparam int                c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]        c_LAST_BYTE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_rd_q;
  logic [3:0]          r_class;
  logic [1:0]          r_byte_idx;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic                r_tx_done;

  state_t              w_state_nxt;
  logic [3:0]          w_class_nxt;
  logic [1:0]          w_byte_idx_nxt;
  logic [c_BAUD_W-1:0] w_baud_nxt;
  logic [2:0]          w_bit_cnt_nxt;
  logic [7:0]          w_shift_nxt;
  logic                w_tx_nxt;
  logic                w_tx_done_nxt;
  logic                w_trigger;
  logic                w_bit_end;
  logic                w_unused;

  // The upper nibble of the result byte carries no class information.
  assign w_unused  = ^din[7:4];

  assign w_trigger = rd & ~r_rd_q;
  assign w_bit_end = (r_baud == c_BAUD_LAST);

  assign TX      = r_tx;
  assign tx_done = r_tx_done;
  assign busy    = (r_state != IDLE);

  // Message content: byte 0 is the class digit (or '?'), then CR, then LF.
  function automatic logic [7:0] byte_for(input logic [1:0] idx, input logic [3:0] cls);
    logic [7:0] b;
    case (idx)
      2'd0: begin
        if (int'({28'd0, cls}) <= MAX_CLASS) b = 8'h30 + {4'd0, cls};
        else                                 b = 8'h3F;
      end
      2'd1:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  // Next-state and datapath decode; TX is computed one cycle ahead so the
  // line itself comes straight from a flop.
  always_comb begin
    w_state_nxt    = r_state;
    w_class_nxt    = r_class;
    w_byte_idx_nxt = r_byte_idx;
    w_baud_nxt     = r_baud;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_tx_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (w_trigger) begin
          // The class is taken from din directly: it is only valid now.
          w_state_nxt    = START;
          w_class_nxt    = din[3:0];
          w_byte_idx_nxt = 2'd0;
          w_bit_cnt_nxt  = 3'd0;
          w_shift_nxt    = byte_for(2'd0, din[3:0]);
          w_tx_nxt       = 1'b0;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_baud_nxt    = '0;
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = 3'd0;
          w_tx_nxt      = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_byte_idx == c_LAST_BYTE) begin
            w_state_nxt   = IDLE;
            w_tx_done_nxt = 1'b1;
            w_tx_nxt      = 1'b1;
          end else begin
            // Next START follows the stop bit with no idle gap.
            w_state_nxt    = START;
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_bit_cnt_nxt  = 3'd0;
            w_shift_nxt    = byte_for(r_byte_idx + 2'd1, r_class);
            w_tx_nxt       = 1'b0;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_baud_nxt  = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any message in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rd_q     <= 1'b0;
      r_class    <= 4'd0;
      r_byte_idx <= 2'd0;
      r_baud     <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_q     <= rd;
      r_class    <= w_class_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_tx_done  <= w_tx_done_nxt;
    end
  end

endmodule
`default_nettype wire
